// File: rtl/elastic_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output slot between N streams.
// Optional packet locking on t_last: define ELASTIC_ARB_LOCK_EN.
module elastic_rr_arbiter #(
  parameter  int N   = 3,
  parameter  int W   = 32,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     t_valid,
  output logic [N-1:0]     t_ready,
  input  logic [N*W-1:0]   t_data,
  input  logic [N-1:0]     t_last,
  output logic             i_valid,
  input  logic             i_ready,
  output logic [W-1:0]     i_data,
  output logic [IDW-1:0]   i_id,
  output logic             i_last
);

  logic           r_valid;
  logic [W-1:0]   r_data;
  logic [IDW-1:0] r_id;
  logic           r_last;
  logic [IDW-1:0] r_ptr;
`ifdef ELASTIC_ARB_LOCK_EN
  logic           r_lock;
  logic [IDW-1:0] r_lock_id;
`endif

  logic           w_slot_free;
  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_next_ptr;
  logic           w_accept;
  int             w_idx;

  assign w_slot_free = ~r_valid | i_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    w_cand   = '0;
    // Descending offsets: the last hit, i.e. the one closest to ptr, wins.
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      w_cand = IDW'(w_idx);
      if (t_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
`ifdef ELASTIC_ARB_LOCK_EN
    if (r_lock) begin
      w_found  = t_valid[r_lock_id];
      w_winner = r_lock_id;
    end
`endif
  end

  always_comb begin
    t_ready = '0;
    if (!rst && w_slot_free && w_found) t_ready[w_winner] = 1'b1;
  end

  assign w_accept   = |(t_valid & t_ready);
  assign w_next_ptr = (w_winner == IDW'(N - 1)) ? '0 : w_winner + IDW'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_id      <= '0;
      r_last    <= 1'b0;
      r_ptr     <= '0;
`ifdef ELASTIC_ARB_LOCK_EN
      r_lock    <= 1'b0;
      r_lock_id <= '0;
`endif
    end else begin
      r_valid <= w_accept | (r_valid & ~i_ready);
      if (w_accept) begin
        r_data <= t_data[int'(w_winner) * W +: W];
        r_id   <= w_winner;
        r_last <= t_last[w_winner];
`ifdef ELASTIC_ARB_LOCK_EN
        // Pointer holds for the whole packet and moves past the owner on its last beat.
        if (t_last[w_winner]) begin
          r_lock <= 1'b0;
          r_ptr  <= w_next_ptr;
        end else begin
          r_lock    <= 1'b1;
          r_lock_id <= w_winner;
        end
`else
        r_ptr <= w_next_ptr;
`endif
      end
    end
  end

  assign i_valid = r_valid;
  assign i_data  = r_data;
  assign i_id    = r_id;
  assign i_last  = r_last;

endmodule

// File: doc/elastic_rr_arbiter.md
Name: elastic_rr_arbiter

Overview:
- Shares one registered elastic (valid/ready) output channel between N requester streams using round-robin arbitration.
- Sits between several elastic producers and a single downstream consumer. The output stage is a one-deep elastic register: full throughput, 1-cycle latency.
- Tags each output beat with the source index.
- Supports packet locking via t_last when compiled in.

Parameters:
- N, 3, number of requester ports (2..16).
- W, 32, data width per port.
- IDW, $clog2(N) (min 1), width of i_id; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset, sampled on posedge clk.
- t_valid  input  N  per-requester valid.
- t_ready  output  N  per-requester ready; one-hot or zero.
- t_data  input  N*W  packed data; port k occupies bits [k*W +: W].
- t_last  input  N  per-requester end-of-packet marker.
- i_valid  output  1  output valid (registered).
- i_ready  input  1  downstream ready.
- i_data  output  W  output data (registered).
- i_id  output  IDW  index of source port for the current beat (registered).
- i_last  output  1  registered copy of the winner's t_last.

Behaviour:
- Reset (rst=1 at posedge):
  - i_valid=0, i_data=0, i_id=0, i_last=0, rr pointer ptr=0, lock=0.
  - While rst=1, t_ready=0 combinationally.
- Output slot free: slot_free = ~i_valid | i_ready (combinational).
- Winner selection (combinational):
  - First k with t_valid[k]=1, searching k = ptr, ptr+1, … N-1, 0, … ptr-1.
  - No t_valid asserted means no winner.
- Ready generation:
  - t_ready[k] = ~rst & slot_free & (k == winner).
  - At most one bit is set.
  - t_ready never depends on t_valid of the same port except via winner selection. Losers see t_ready=0.
- Transfer accept: accept = |(t_valid & t_ready).
  - On accept: i_data<=t_data[winner], i_id<=winner, i_last<=t_last[winner], ptr<=(winner+1) mod N.
- i_valid update: i_valid <= accept | (i_valid & ~i_ready).
  - The registered beat is held stable (data, id, last) while i_valid=1 and i_ready=0.
- Simultaneous pop and push: i_valid=1, i_ready=1 and a winner present → new beat loaded the same cycle. Sustained throughput is 1 beat/clk.
- Latency: t-side accept at edge n → beat visible on i_* after edge n; earliest downstream accept is edge n+1.
- Fairness:
  - With all N ports continuously valid and i_ready=1, grants rotate 0,1,…,N-1,0,…
  - Starvation-free: any port waits at most N-1 grants.
- Wrap: ptr wraps from N-1 to 0. When N is not a power of two, ptr never takes values ≥ N.
- Idle: no t_valid → ptr unchanged, no state change other than draining i_valid.
- Reset mid-transfer: a pending i_valid beat is discarded; arbitration restarts at port 0.
- Data is passed through unmodified; no width conversion.

Optional Feature:
- Macro: ELASTIC_ARB_LOCK_EN.
- Defined:
  - Accepting a beat with t_last=0 sets lock=1 and lock_id=winner.
  - While lock=1, winner = lock_id if t_valid[lock_id]; otherwise no winner. Other ports are not granted even if valid.
  - ptr does not advance during a locked packet.
  - Accepting a beat with t_last=1 clears lock and sets ptr=lock_id+1 mod N.
  - Reset clears lock.
- Not defined: t_last is ignored for arbitration (only forwarded to i_last); every beat re-arbitrates; no lock state exists.

Test Plan:
- Reset: assert rst for 2 clk with all t_valid=1 → t_ready=0, i_valid=0, i_data=0, i_id=0 throughout.
- Round-robin with N=3, W=32:
  - Stimulus: all ports valid continuously, t_data[k]=0x100+k, i_ready=1.
  - Expected: i_id sequence 0,1,2,0,1,2; i_data sequence 0x100,0x101,0x102,…; i_valid=1 every cycle after the first.
- Backpressure:
  - Stimulus: port 1 sends 0xDEADBEEF, then i_ready=0 for 4 clk.
  - Expected: i_data/i_id stay 0xDEADBEEF/1, t_ready=0 on all ports, and no beat is lost. After i_ready=1, the next winner is port 2 (if valid).
- Sparse requests:
  - Stimulus: only port 2 valid, i_ready=1.
  - Expected: port 2 is granted every cycle and ptr wraps to 0 each grant.
  - Then ports 0 and 2 are valid with ptr=0 → port 0 is granted first.
- Lock (ELASTIC_ARB_LOCK_EN):
  - Stimulus: port 0 sends 3 beats with t_last=0,0,1 while port 1 is continuously valid.
  - Expected: i_id=0,0,0, then 1. With the macro undefined, the expected order is 0,1,0,1,0.
- Reset mid-operation: assert rst while i_valid=1 and i_ready=0 → after the edge i_valid=0, and the next grant goes to port 0.
